// File: rtl/uart_tx_arbiter.sv
// Round-robin packetiser sharing one UART TX byte port: SYNC, ID, LEN, payload, XOR checksum.
// Grant 1 cycle after request, one byte per cycle; i_uart_ready low freezes state, byte and counters.
module uart_tx_arbiter #(
  parameter int         NumSources = 4,
  parameter logic [7:0] SyncByte   = 8'hA5
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NumSources-1:0]   i_req,
  input  logic [8*NumSources-1:0] i_len,
  input  logic [NumSources-1:0]   i_valid,
  input  logic [8*NumSources-1:0] i_data,
  output logic [NumSources-1:0]   o_grant,
  output logic [NumSources-1:0]   o_ack,
  output logic [NumSources-1:0]   o_done,
  output logic [7:0]              o_frame,
  output logic                    o_frame_valid,
  input  logic                    i_uart_ready
);

  localparam int IW = (NumSources > 1) ? $clog2(NumSources) : 1;

  typedef enum logic [2:0] {IDLE, SYNC, ID, LEN, PAYLOAD, CSUM} state_t;

  state_t                r_state;
  logic [IW-1:0]         r_ptr;
  logic [IW-1:0]         r_gidx;
  logic [NumSources-1:0] r_grant;
  logic [7:0]            r_cnt;
  logic [7:0]            r_csum;
  logic [7:0]            r_frame;
  logic                  r_frame_valid;

  logic                  w_found;
  logic                  w_hi_found;
  logic [IW-1:0]         w_hi;
  logic [IW-1:0]         w_lo;
  logic [IW-1:0]         w_pick;
  logic [NumSources-1:0] w_pick_oh;
  logic [7:0]            w_len_pick;
  logic [7:0]            w_src_data;
  logic                  w_src_valid;
  logic [7:0]            w_out_byte;
  logic                  w_out_valid;
  logic                  w_xfer;
  logic [IW-1:0]         w_ptr_next;

  // Descending scan leaves the lowest requester at/after the pointer in w_hi, lowest overall in w_lo.
  always_comb begin
    w_found    = 1'b0;
    w_hi_found = 1'b0;
    w_hi       = '0;
    w_lo       = '0;
    for (int k = NumSources - 1; k >= 0; k--) begin
      if (i_req[k]) begin
        w_found = 1'b1;
        w_lo    = IW'(k);
        if (IW'(k) >= r_ptr) begin
          w_hi_found = 1'b1;
          w_hi       = IW'(k);
        end
      end
    end
    w_pick = w_hi_found ? w_hi : w_lo;

    w_pick_oh  = '0;
    w_len_pick = '0;
    for (int k = 0; k < NumSources; k++) begin
      if (IW'(k) == w_pick) begin
        w_pick_oh[k] = 1'b1;
        w_len_pick   = i_len[8*k +: 8];
      end
    end
  end

  always_comb begin
    w_src_data  = '0;
    w_src_valid = 1'b0;
    for (int k = 0; k < NumSources; k++) begin
      if (r_grant[k]) begin
        w_src_data  = w_src_data | i_data[8*k +: 8];
        w_src_valid = w_src_valid | i_valid[k];
      end
    end
  end

  // Only the payload phase passes the source straight through; header and checksum are registered.
  assign w_out_byte  = (r_state == PAYLOAD) ? w_src_data  : r_frame;
  assign w_out_valid = (r_state == PAYLOAD) ? w_src_valid : r_frame_valid;
  assign w_xfer      = w_out_valid & i_uart_ready;
  assign w_ptr_next  = (r_gidx == IW'(NumSources - 1)) ? '0 : r_gidx + 1'b1;

  assign o_frame       = w_out_byte;
  assign o_frame_valid = w_out_valid;
  assign o_grant       = r_grant;
  assign o_ack         = ((r_state == PAYLOAD) && w_xfer) ? r_grant : '0;
  assign o_done        = ((r_state == CSUM) && w_xfer) ? r_grant : '0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_gidx        <= '0;
      r_grant       <= '0;
      r_cnt         <= '0;
      r_csum        <= '0;
      r_frame       <= '0;
      r_frame_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant       <= w_pick_oh;
            r_gidx        <= w_pick;
            r_cnt         <= w_len_pick;
            r_csum        <= '0;
            r_frame       <= SyncByte;
            r_frame_valid <= 1'b1;
            r_state       <= SYNC;
          end
        end
        SYNC: begin
          if (w_xfer) begin
            r_frame <= 8'(r_gidx);
            r_state <= ID;
          end
        end
        ID: begin
          if (w_xfer) begin
            r_csum  <= r_csum ^ r_frame;
            r_frame <= r_cnt;
            r_state <= LEN;
          end
        end
        LEN: begin
          if (w_xfer) begin
            r_csum <= r_csum ^ r_frame;
            if (r_cnt == 8'd0) begin
              r_frame <= r_csum ^ r_frame;
              r_state <= CSUM;
            end else begin
              r_frame       <= '0;
              r_frame_valid <= 1'b0;
              r_state       <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (w_xfer) begin
            r_csum <= r_csum ^ w_src_data;
            r_cnt  <= r_cnt - 8'd1;
            if (r_cnt == 8'd1) begin
              r_frame       <= r_csum ^ w_src_data;
              r_frame_valid <= 1'b1;
              r_state       <= CSUM;
            end
          end
        end
        CSUM: begin
          if (w_xfer) begin
            r_grant       <= '0;
            r_ptr         <= w_ptr_next;
            r_frame       <= '0;
            r_frame_valid <= 1'b0;
            r_state       <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: byte streams, grant order, stalls and reset abort.
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic           CLK = 1'b0;
  logic           RST;
  logic [N-1:0]   i_req;
  logic [8*N-1:0] i_len;
  logic [N-1:0]   i_valid;
  logic [8*N-1:0] i_data;
  logic [N-1:0]   o_grant;
  logic [N-1:0]   o_ack;
  logic [N-1:0]   o_done;
  logic [7:0]     o_frame;
  logic           o_frame_valid;
  logic           i_uart_ready;

  always #5 CLK = ~CLK;

  uart_tx_arbiter #(.NumSources(N), .SyncByte(8'hA5)) dut (
    .CLK(CLK), .RST(RST), .i_req(i_req), .i_len(i_len), .i_valid(i_valid),
    .i_data(i_data), .o_grant(o_grant), .o_ack(o_ack), .o_done(o_done),
    .o_frame(o_frame), .o_frame_valid(o_frame_valid), .i_uart_ready(i_uart_ready)
  );

  logic [7:0] pay [N][16];
  int         pidx [N];
  int         done_cnt [N];
  logic [N-1:0] vld_en, req_hold;
  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];
  int         grant_log [$];
  int         total = 0;
  int         bad = 0;
  int         ack_cnt, fv_low;
  logic [N-1:0] s_grant, s_ack, s_done, prev_grant;
  logic [7:0] s_frame;
  logic       s_fv;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      i_data[8*k +: 8] = pay[k][pidx[k]];
      i_valid[k]       = vld_en[k];
    end
  endtask

  // Sample at negedge, then update sources just after the next posedge.
  task automatic step();
    @(negedge CLK);
    s_grant = o_grant; s_ack = o_ack; s_done = o_done; s_frame = o_frame; s_fv = o_frame_valid;
    if (o_frame_valid && i_uart_ready) got_q.push_back(o_frame);
    for (int k = 0; k < N; k++) begin
      if (o_ack[k]) ack_cnt++;
      if (o_done[k]) done_cnt[k]++;
      if (o_grant[k] && !prev_grant[k]) grant_log.push_back(k);
    end
    if (o_grant != '0 && !o_frame_valid) fv_low++;
    prev_grant = o_grant;
    @(posedge CLK);
    #1;
    for (int k = 0; k < N; k++) begin
      if (s_ack[k]) pidx[k] = (pidx[k] + 1) % 16;
      if (s_grant[k] && !req_hold[k]) i_req[k] = 1'b0;
    end
    drive();
  endtask

  task automatic clear_counts();
    got_q.delete();
    grant_log.delete();
    ack_cnt = 0;
    fv_low  = 0;
    for (int k = 0; k < N; k++) done_cnt[k] = 0;
  endtask

  task automatic request(input int k, input logic [7:0] len);
    i_len[8*k +: 8] = len;
    pidx[k]  = 0;
    i_req[k] = 1'b1;
    drive();
  endtask

  task automatic wait_done(input string tag, input int k, input int budget);
    int n = 0;
    int d0 = done_cnt[k];
    while (done_cnt[k] == d0 && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_done"}, 32'(done_cnt[k] - d0), 32'd1);
  endtask

  task automatic wait_acks(input int target, input int budget);
    int n = 0;
    while (ack_cnt < target && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  task automatic do_reset();
    RST   = 1'b1;
    i_req = '0;
    step();
    step();
    RST = 1'b0;
    prev_grant = '0;
  endtask

  initial begin
    RST = 1'b1; i_req = '0; i_len = '0; i_valid = '0; i_data = '0;
    i_uart_ready = 1'b1; vld_en = '1; req_hold = '0; prev_grant = '0;
    for (int k = 0; k < N; k++) begin
      pidx[k] = 0;
      for (int i = 0; i < 16; i++) pay[k][i] = 8'h00;
    end
    clear_counts();
    do_reset();
    step();
    chk("rst_grant", 32'(s_grant), 32'd0);
    chk("rst_ack", 32'(s_ack), 32'd0);
    chk("rst_done", 32'(s_done), 32'd0);
    chk("rst_fv", 32'(s_fv), 32'd0);
    chk("rst_frame", 32'(s_frame), 32'd0);

    // 1: basic packet, source 1
    clear_counts();
    pay[1][0] = 8'h11; pay[1][1] = 8'h22; pay[1][2] = 8'h33;
    request(1, 8'd3);
    step();
    chk("t1_nogrant_yet", 32'(s_grant), 32'd0);
    step();
    chk("t1_grant", 32'(s_grant), 32'h2);
    wait_done("t1", 1, 30);
    step(); step();
    exp_q = {8'hA5, 8'h01, 8'h03, 8'h11, 8'h22, 8'h33, 8'h02};
    check_stream("t1");
    chk("t1_acks", 32'(ack_cnt), 32'd3);
    chk("t1_done_once", 32'(done_cnt[1]), 32'd1);

    // 2: sources 0 and 2 requesting continuously
    do_reset();
    clear_counts();
    pay[0][0] = 8'h5A; pay[0][1] = 8'h5A; pay[2][0] = 8'hC3; pay[2][1] = 8'hC3;
    req_hold = 4'b0101;
    request(0, 8'd1);
    request(2, 8'd1);
    for (int n = 0; n < 80 && grant_log.size() < 4; n++) step();
    req_hold = '0;
    i_req = '0;
    wait_done("t2", 2, 30);
    chk("t2_ngrants", 32'(grant_log.size()), 32'd4);
    if (grant_log.size() == 4) begin
      chk("t2_order0", 32'(grant_log[0]), 32'd0);
      chk("t2_order1", 32'(grant_log[1]), 32'd2);
      chk("t2_order2", 32'(grant_log[2]), 32'd0);
      chk("t2_order3", 32'(grant_log[3]), 32'd2);
    end
    exp_q = {8'hA5, 8'h00, 8'h01, 8'h5A, 8'h5B, 8'hA5, 8'h02, 8'h01, 8'hC3, 8'hC0,
             8'hA5, 8'h00, 8'h01, 8'h5A, 8'h5B, 8'hA5, 8'h02, 8'h01, 8'hC3, 8'hC0};
    check_stream("t2");

    // 2b: pointer at 1 after source 0; source 2 wins over source 0
    do_reset();
    clear_counts();
    request(0, 8'd1);
    wait_done("t2b_a", 0, 20);
    request(0, 8'd1);
    request(2, 8'd1);
    step(); step();
    chk("t2b_rr_grant", 32'(s_grant), 32'h4);
    wait_done("t2b_c", 0, 30);

    // 3: UART stall during payload byte 2
    clear_counts();
    pay[0][0] = 8'h10; pay[0][1] = 8'h20; pay[0][2] = 8'h30; pay[0][3] = 8'h40;
    request(0, 8'd4);
    wait_acks(1, 20);
    i_uart_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      step();
      chk($sformatf("t3_stall_frame%0d", n), 32'(s_frame), 32'h20);
    end
    i_uart_ready = 1'b1;
    wait_done("t3", 0, 30);
    exp_q = {8'hA5, 8'h00, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'h44};
    check_stream("t3");
    chk("t3_acks", 32'(ack_cnt), 32'd4);

    // 4: zero-length packet
    clear_counts();
    request(3, 8'd0);
    wait_done("t4", 3, 20);
    exp_q = {8'hA5, 8'h03, 8'h00, 8'h03};
    check_stream("t4");
    chk("t4_acks", 32'(ack_cnt), 32'd0);

    // 5: source stall mid-payload
    clear_counts();
    pay[1][0] = 8'h01; pay[1][1] = 8'h80; pay[1][2] = 8'h7F; pay[1][3] = 8'hFE;
    request(1, 8'd4);
    wait_acks(2, 20);
    vld_en[1] = 1'b0;
    drive();
    step(); step(); step();
    vld_en[1] = 1'b1;
    drive();
    wait_done("t5", 1, 30);
    exp_q = {8'hA5, 8'h01, 8'h04, 8'h01, 8'h80, 8'h7F, 8'hFE, 8'h05};
    check_stream("t5");
    chk("t5_fv_low", 32'(fv_low), 32'd3);

    // 6: reset in PAYLOAD, then a fresh packet
    clear_counts();
    pay[2][0] = 8'h01; pay[2][1] = 8'h02; pay[2][2] = 8'h03; pay[2][3] = 8'h04; pay[2][4] = 8'h05;
    request(2, 8'd5);
    wait_acks(2, 20);
    RST = 1'b1;
    step();
    RST = 1'b0;
    prev_grant = '0;
    step();
    chk("t6_grant", 32'(s_grant), 32'd0);
    chk("t6_ack", 32'(s_ack), 32'd0);
    chk("t6_done", 32'(s_done), 32'd0);
    chk("t6_fv", 32'(s_fv), 32'd0);
    chk("t6_frame", 32'(s_frame), 32'd0);
    clear_counts();
    pay[0][0] = 8'hAA; pay[0][1] = 8'hBB;
    request(0, 8'd2);
    wait_done("t6", 0, 20);
    exp_q = {8'hA5, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'h13};
    check_stream("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit byte interface between NumSources independent requesters, such as a VGA frame-dump engine and debug/status producers.
- Grants the link to one source at a time using round-robin arbitration, and only at packet boundaries.
- Wraps each source's payload in a packet: sync byte, source ID, length, payload bytes, XOR checksum.
- Sits directly in front of the UART TX FIFO: drives its write strobe and byte input, and obeys its space-available flag.

Parameters:
- NumSources, 4, number of requesters; legal range 2..16.
- SyncByte, 8'hA5, first byte of every packet.

Ports:
- CLK  input  1  system clock.
- RST  input  1  synchronous, active-high reset.
- i_req  input  NumSources  per-source packet request; held high until the matching o_grant bit is seen.
- i_len  input  8*NumSources  per-source payload length, 0..255; source k uses bits [8k+7:8k]; held stable while i_req is high.
- i_valid  input  NumSources  per-source payload byte valid.
- i_data  input  8*NumSources  per-source payload byte; source k uses bits [8k+7:8k].
- o_grant  output  NumSources  one-hot; bit of the source that owns the current packet.
- o_ack  output  NumSources  payload byte of the granted source consumed this cycle.
- o_done  output  NumSources  one-cycle pulse when the checksum byte of that source's packet is accepted.
- o_frame  output  8  byte to the UART.
- o_frame_valid  output  1  byte valid; drives the UART write strobe.
- i_uart_ready  input  1  UART FIFO has space; a byte transfers on any cycle where o_frame_valid and i_uart_ready are both high.

Behaviour:
- Reset (RST=1 at a clock edge):
  - state=IDLE; round-robin pointer=0.
  - o_grant=0, o_ack=0, o_done=0, o_frame_valid=0, o_frame=0.
  - Reset mid-packet aborts the packet immediately; no further bytes are emitted.
  - The truncated packet downstream is acceptable; the receiver resyncs on SyncByte.
- FSM states: IDLE, SYNC, ID, LEN, PAYLOAD, CSUM.
- IDLE:
  - If any i_req bit is high, select the first requesting index at or after the pointer, wrapping modulo NumSources.
  - Register o_grant one-hot; latch i_len into a length counter; clear the checksum; go to SYNC.
  - Grant latency is 1 cycle after i_req is sampled.
  - i_req dropped before the grant edge: that source is not granted.
- SYNC:
  - o_frame=SyncByte, o_frame_valid=1.
  - Advance to ID on transfer.
  - SyncByte is not included in the checksum.
- ID:
  - o_frame = granted index, zero-extended to 8 bits.
  - checksum ^= byte; advance to LEN on transfer.
- LEN:
  - o_frame = latched length; checksum ^= byte.
  - On transfer go to PAYLOAD, or to CSUM if length==0.
- PAYLOAD:
  - o_frame = i_data of the granted source (combinational mux); o_frame_valid = i_valid of the granted source.
  - o_ack[g] = i_valid[g] & i_uart_ready.
  - On each transfer: checksum ^= byte; decrement the counter; after the last byte go to CSUM.
  - If the source stalls (i_valid low), o_frame_valid is low; no bubble byte is inserted.
- CSUM:
  - o_frame = checksum register; o_frame_valid=1.
  - On transfer: pulse o_done[g]; set pointer = (g+1) mod NumSources; clear o_grant; go to IDLE.
- In SYNC, ID, LEN and CSUM, o_frame and o_frame_valid are registered state outputs, not dependent on source inputs.
- Backpressure: while i_uart_ready=0 the FSM holds its state, byte and counters; no byte is dropped or duplicated.
- The arbiter ignores i_req of the granted source and of all other sources during a packet. Changes to i_len after the grant are ignored.
- Minimum idle gap: one cycle in IDLE between packets. Throughput is otherwise one byte per cycle when the UART is ready.
- i_req and i_valid bits of non-granted sources never produce o_ack.

Test Plan:
1. Source 1, i_len=3, payload 11,22,33; i_uart_ready=1.
   - UART sees A5 01 03 11 22 33 02.
   - o_ack[1] pulses 3 times; o_done[1] pulses once.
2. Sources 0 and 2 request continuously with i_len=1 each.
   - Grant order is 0,2,0,2.
   - Source 2 requesting alone after pointer=1 is granted next.
3. i_uart_ready held low for 5 cycles during payload byte 2 of a 4-byte packet.
   - Byte stream is unchanged; o_ack count is 4; o_frame is stable throughout the stall.
4. Source 3, i_len=0.
   - UART sees A5 03 00 03; no o_ack pulses; o_done[3] pulses.
5. Granted source drops i_valid for 3 cycles mid-payload.
   - o_frame_valid is low for exactly those cycles; the checksum is still correct.
6. RST asserted while in PAYLOAD.
   - Next cycle: all outputs 0, state IDLE.
   - Fresh request from source 0 yields a complete packet starting with A5.
